// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: per-channel synchroniser and glitch filter, then a
// Gray-code transition decoder driving a wrapping up/down position count.

module quad_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  input  logic i_load,
  output logic o_sync,
  output logic o_filt
);
  localparam int K_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic [K_W-1:0]         r_k;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
  end

  // The filtered value only follows the synced value after FILT_LEN
  // consecutive disagreeing cycles; the load bypasses that at start-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt <= 1'b0;
      r_k    <= '0;
    end else if (i_load) begin
      r_filt <= w_s;
      r_k    <= '0;
    end else if (w_s == r_filt) begin
      r_k    <= '0;
    end else if (r_k == K_W'(FILT_LEN-1)) begin
      r_filt <= w_s;
      r_k    <= '0;
    end else begin
      r_k    <= r_k + 1'b1;
    end
  end

  assign o_sync = w_s;
  assign o_filt = r_filt;
endmodule

module quad_decoder #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ch_a,
  input  logic             ch_b,
  input  logic             en,
  input  logic             clr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             up_down,
  output logic             step,
  output logic             err
);
  localparam int IC_W = $clog2(SYNC_STAGES+1);

  typedef enum logic [0:0] {ST_INIT, ST_TRACK} state_t;

  state_t            r_state, w_next;
  logic [IC_W-1:0]   r_init_cnt;
  logic [1:0]        w_async, w_sync, w_cur;
  logic [1:0]        r_prev;
  logic              w_load, w_track;
  logic              w_up, w_dn, w_illegal;
  logic [CNT_W-1:0]  r_count;
  logic              r_up_down, r_step, r_err;

  // Bit 1 is channel A, bit 0 is channel B.
  assign w_async = {ch_a, ch_b};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_chan
      quad_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
      ) u_chan (
        .clk     (clk),
        .reset   (reset),
        .i_async (w_async[g]),
        .i_load  (w_load),
        .o_sync  (w_sync[g]),
        .o_filt  (w_cur[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_next;
      if (r_state == ST_INIT && r_init_cnt != IC_W'(SYNC_STAGES))
        r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:  if (r_init_cnt == IC_W'(SYNC_STAGES)) w_next = ST_TRACK;
      ST_TRACK: w_next = ST_TRACK;
      default:  w_next = ST_INIT;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_track = 1'b0;
    case (r_state)
      ST_INIT:  w_load  = (r_init_cnt == IC_W'(SYNC_STAGES));
      ST_TRACK: w_track = 1'b1;
      default:  ;
    endcase
  end

  // Up order 00->10->11->01->00 means next_up = {~b, a}; down is its inverse.
  assign w_up      = w_track && (w_cur == {~r_prev[0], r_prev[1]});
  assign w_dn      = w_track && (w_cur == {r_prev[0], ~r_prev[1]});
  assign w_illegal = w_track && (&(w_cur ^ r_prev));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_prev <= 2'b00;
    else if (w_load)  r_prev <= w_sync;
    else if (w_track) r_prev <= w_cur;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_up_down <= 1'b0;
      r_step    <= 1'b0;
    end else if (clr) begin
      r_count   <= '0;
      r_step    <= 1'b0;
    end else if (en && (w_up || w_dn)) begin
      r_count   <= w_up ? r_count + 1'b1 : r_count - 1'b1;
      r_up_down <= w_up;
      r_step    <= 1'b1;
    end else begin
      r_step    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_err <= 1'b0;
    else if (w_illegal) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

  assign count   = r_count;
  assign up_down = r_up_down;
  assign step    = r_step;
  assign err     = r_err;
endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with hand-computed expectations.

module tb_quad_decoder;
  logic       clk, reset, ch_a, ch_b, en, clr, err_clr;
  logic [3:0] count;
  logic       up_down, step, err;

  int n_chk, n_fail, n_steps;

  quad_decoder dut (
    .clk     (clk),
    .reset   (reset),
    .ch_a    (ch_a),
    .ch_b    (ch_b),
    .en      (en),
    .clr     (clr),
    .err_clr (err_clr),
    .count   (count),
    .up_down (up_down),
    .step    (step),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every cycle step is high, so a stretched pulse counts twice.
  always @(negedge clk) if (step === 1'b1) n_steps++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ab(input logic [1:0] ab);
    ch_a = ab[1];
    ch_b = ab[0];
  endtask

  initial begin
    logic [1:0] up_seq [4];
    int s0;
    up_seq[0] = 2'b01; up_seq[1] = 2'b00; up_seq[2] = 2'b10; up_seq[3] = 2'b11;
    n_chk = 0; n_fail = 0;
    reset = 1'b0; en = 1'b1; clr = 1'b0; err_clr = 1'b0;
    set_ab(2'b11);
    tick(3);
    chk("rst_count", count, 0);
    chk("rst_updown", up_down, 0);
    chk("rst_step", step, 0);
    chk("rst_err", err, 0);

    // release with both channels high: nothing may count
    s0 = n_steps;
    reset = 1'b1;
    tick(10);
    chk("init_count", count, 0);
    chk("init_err", err, 0);
    chk("init_steps", n_steps - s0, 0);

    // four full up cycles with latency check on the first edge
    s0 = n_steps;
    for (int i = 0; i < 16; i++) begin
      set_ab(up_seq[i % 4]);
      if (i == 0) begin
        tick(5);
        chk("lat5_step", step, 0);
        tick(1);
        chk("lat6_step", step, 1);
        chk("lat6_count", count, 1);
        chk("lat6_updown", up_down, 1);
        tick(4);
      end else begin
        tick(10);
      end
      chk($sformatf("up_count%0d", i), count, (i + 1) % 16);
    end
    chk("up_steps", n_steps - s0, 16);
    chk("up_updown", up_down, 1);

    // reach 00, clear, then two down edges
    set_ab(2'b01); tick(10);
    set_ab(2'b00); tick(10);
    chk("pre_clr_count", count, 2);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clr_count", count, 0);
    set_ab(2'b01); tick(10);
    chk("dn1_count", count, 15);
    chk("dn1_updown", up_down, 0);
    set_ab(2'b11); tick(10);
    chk("dn2_count", count, 14);
    chk("dn_err", err, 0);

    // 2-cycle glitch on A is filtered out
    s0 = n_steps;
    ch_a = 1'b0; tick(2); ch_a = 1'b1; tick(10);
    chk("glitch_steps", n_steps - s0, 0);
    chk("glitch_count", count, 14);
    chk("glitch_err", err, 0);

    // illegal 11->00
    s0 = n_steps;
    set_ab(2'b00); tick(10);
    chk("ill_err", err, 1);
    chk("ill_count", count, 14);
    chk("ill_steps", n_steps - s0, 0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("errclr_err", err, 0);

    // err_clr coincident with illegal 00->11: set wins
    set_ab(2'b11); tick(5);
    chk("ill2_pre_err", err, 0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("ill2_setwins", err, 1);
    tick(4);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("ill2_cleared", err, 0);

    // disabled counting over three up edges, then one enabled edge
    en = 1'b0;
    set_ab(2'b01); tick(10);
    set_ab(2'b00); tick(10);
    set_ab(2'b10); tick(10);
    chk("en0_count", count, 14);
    chk("en0_updown", up_down, 0);
    chk("en0_err", err, 0);
    en = 1'b1;
    set_ab(2'b11); tick(10);
    chk("en1_count", count, 15);
    chk("en1_updown", up_down, 1);
    chk("en1_err", err, 0);

    // clr in the cycle of a down step
    s0 = n_steps;
    set_ab(2'b10); tick(5);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clrstep_count", count, 0);
    chk("clrstep_step", step, 0);
    chk("clrstep_updown", up_down, 1);
    tick(4);
    chk("clrstep_steps", n_steps - s0, 0);
    chk("clrstep_err", err, 0);

    // build up state, then async reset mid-sequence
    set_ab(2'b11); tick(10);
    chk("pre_rst_count", count, 1);
    set_ab(2'b00); tick(10);
    chk("pre_rst_err", err, 1);
    set_ab(2'b10); tick(3);
    reset = 1'b0; #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_updown", up_down, 0);
    chk("mid_rst_step", step, 0);
    chk("mid_rst_err", err, 0);
    tick(1);
    reset = 1'b1;
    tick(10);
    chk("reinit_count", count, 0);
    chk("reinit_err", err, 0);
    set_ab(2'b11); tick(10);
    chk("post_rst_count", count, 1);
    chk("post_rst_updown", up_down, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature (A/B) decoder that turns two-phase encoder signals into an up/down count.
- Supplies the direction and step events that drive the team's up/down counter datapath.
- Internal count mirrors the 4-bit counter by default.
- Inputs are asynchronous: each channel is synchronised and glitch-filtered, then the Gray-code state is decoded into up step, down step, or illegal transition.

Parameters:
CNT_W, 4, width of count output; count wraps modulo 2^CNT_W
SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2)
FILT_LEN, 3, consecutive cycles a synced channel must differ from its filtered value before the filtered value updates (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
ch_a  input  1  encoder channel A, asynchronous
ch_b  input  1  encoder channel B, asynchronous
en  input  1  count enable; when 0, state is tracked but count is frozen
clr  input  1  synchronous clear of count
err_clr  input  1  synchronous clear of err
count  output  CNT_W  position count
up_down  output  1  direction of last counted step (1=up, 0=down)
step  output  1  one-cycle pulse per counted step
err  output  1  sticky illegal-transition flag

Behaviour:
- Reset (reset=0, async) clears all state:
  - synchronisers, filtered values and filter counters = 0
  - count=0, up_down=0, step=0, err=0
  - FSM enters INIT
- Filter, per channel, on each cycle, with s = synced value, f = filtered value, k = counter:
  - if s==f: k=0
  - else if k==FILT_LEN-1: f=s, k=0
  - else: k=k+1
- FSM INIT:
  - Holds for SYNC_STAGES+1 cycles after reset deasserts.
  - On the last INIT cycle, f_a/f_b load the synced values directly and prev={f_a,f_b}.
  - Then moves to TRACK. No counting or err in INIT.
- FSM TRACK: each cycle compare cur={f_a,f_b} to prev, then set prev=cur.
  - Up sequence (A leads): 00->10->11->01->00.
  - Down sequence: 00->01->11->10->00.
  - cur==prev: no action; step=0.
  - Valid up or down with en=1: count +/-1 modulo 2^CNT_W (1111+1=0000, 0000-1=1111), step=1 for exactly one cycle, up_down updated.
  - Valid step with en=0: count, up_down and step unchanged; prev still updates.
  - Illegal (both bits changed): err=1, no count, no step; prev resyncs to cur; remain in TRACK.
- Registered outputs; latency from an input edge (stable thereafter) to step/count update = SYNC_STAGES+FILT_LEN+1 cycles (6 with defaults).
- Pulses shorter than FILT_LEN synced cycles are rejected: f unchanged, no step.
- clr=1: count=0 and step=0 that cycle, overriding a simultaneous step; up_down unchanged; prev still updates.
- Simultaneous err_clr and illegal transition: err remains 1 (set wins).
- err_clr alone: err=0 next cycle.
- reset asserted mid-operation: immediate async clear to reset values; the INIT sequence repeats on release.

Test Plan:
- Reset release with ch_a=ch_b=1 held: no step and err=0 after INIT; count=0.
- Four full up cycles (16 edges, each held 10 clk): count 0->15->0 wrap seen, 16 step pulses, up_down=1; first step exactly 6 clk after first edge.
- Two down edges from count=0 (00->01->11): count 0->15->14, up_down=0, err=0.
- 2-clk glitch on ch_a (FILT_LEN=3): no step; count unchanged.
- Forced 00->11 (both channels toggled same cycle): err=1, count unchanged.
  - Then err_clr pulsed: err=0.
  - err_clr asserted in the same cycle as a second illegal transition: err stays 1.
- en=0 during 3 up edges, then en=1 and 1 up edge: count +1 only, no error.
- clr in the same cycle as a step: count=0, step=0.
- reset pulsed mid-sequence: all outputs return to 0.
